// File: rtl/physics_frame_scheduler.sv
// physics_frame_scheduler
// Runs one physics frame per accepted frame tick: SUBSTEPS integration
// passes, then every unordered sprite pair (i<j) in lexicographic order
// through the shared collision unit, then a one-cycle commit pulse.
//
// Handshakes:
//   integ_start_o / integ_done_i : one-cycle pulse out, one-cycle pulse back.
//   pair_valid_o / pair_ready_i  : a pair transfers on any cycle where both
//     are high; pair_i_o, pair_j_o and pair_last_o hold steady while
//     pair_valid_o is high and pair_ready_i is low. pair_valid_o never drops
//     without a transfer except on reset.
//
// All outputs come from registers or from the state register alone.
module physics_frame_scheduler #(
    parameter int SPRITES  = 2,
    parameter int SUBSTEPS = 1,
    parameter int IDX_W    = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             frame_tick_i,
    input  logic             run_i,
    input  logic             step_btn_i,
    output logic             integ_start_o,
    input  logic             integ_done_i,
    output logic             pair_valid_o,
    input  logic             pair_ready_i,
    output logic [IDX_W-1:0] pair_i_o,
    output logic [IDX_W-1:0] pair_j_o,
    output logic             pair_last_o,
    output logic             commit_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic [15:0]      frame_count_o,
    output logic [2:0]       state_dbg_o
);

    localparam int SUB_W      = (SUBSTEPS > 1) ? $clog2(SUBSTEPS) : 1;
    localparam int LAST_I_INT = (SPRITES >= 2) ? SPRITES - 2 : 0;
    localparam int LAST_J_INT = (SPRITES >= 1) ? SPRITES - 1 : 0;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUBSTEPS - 1);
    localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(LAST_I_INT);
    localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(LAST_J_INT);
    // With exactly two sprites the first pair is also the final one.
    localparam logic             ONE_PAIR = (SPRITES == 2);
    localparam logic             NO_PAIRS = (SPRITES < 2);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INTEG      = 3'd1,
        ST_WAIT_INTEG = 3'd2,
        ST_PAIRS      = 3'd3,
        ST_COMMIT     = 3'd4
    } state_t;

    state_t           state_q;
    logic             integ_start_q;
    logic             pair_valid_q;
    logic [IDX_W-1:0] pair_i_q;
    logic [IDX_W-1:0] pair_j_q;
    logic             pair_last_q;
    logic             commit_q;
    logic             overrun_q;
    logic [15:0]      frame_count_q;
    logic             step_pending_q;
    logic [SUB_W-1:0] substep_q;
    logic             step_q;

    logic             step_edge;
    logic             frame_start;
    logic             step_pending_d;
    logic [IDX_W-1:0] pair_i_d;
    logic [IDX_W-1:0] pair_j_d;
    logic             pair_last_d;

    // Step request bookkeeping: a pending step is consumed by the frame it starts.
    always_comb begin
        step_edge      = step_btn_i & ~step_q;
        frame_start    = (state_q == ST_IDLE) && frame_tick_i && (run_i || step_pending_q);
        step_pending_d = step_pending_q;
        if (frame_start) begin
            step_pending_d = 1'b0;
        end
        if (step_edge && !run_i) begin
            step_pending_d = 1'b1;
        end
    end

    // Next pair in lexicographic order, and whether that pair is the final one.
    always_comb begin
        pair_i_d = pair_i_q;
        pair_j_d = pair_j_q;
        if (pair_j_q < LAST_J) begin
            pair_j_d = pair_j_q + IDX_W'(1);
        end else begin
            pair_i_d = pair_i_q + IDX_W'(1);
            pair_j_d = pair_i_d + IDX_W'(1);
        end
        pair_last_d = (pair_i_d == LAST_I) && (pair_j_d == LAST_J);
    end

    // Frame sequencer with registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            integ_start_q  <= 1'b0;
            pair_valid_q   <= 1'b0;
            pair_i_q       <= '0;
            pair_j_q       <= IDX_W'(1);
            pair_last_q    <= 1'b0;
            commit_q       <= 1'b0;
            overrun_q      <= 1'b0;
            frame_count_q  <= 16'd0;
            step_pending_q <= 1'b0;
            substep_q      <= '0;
            step_q         <= 1'b0;
        end else begin
            step_q         <= step_btn_i;
            step_pending_q <= step_pending_d;
            integ_start_q  <= 1'b0;
            commit_q       <= 1'b0;

            // A tick that lands mid-frame is dropped but remembered as an overrun.
            if (frame_tick_i && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q       <= ST_INTEG;
                        integ_start_q <= 1'b1;
                        substep_q     <= '0;
                    end
                end
                ST_INTEG: begin
                    state_q <= ST_WAIT_INTEG;
                end
                ST_WAIT_INTEG: begin
                    if (integ_done_i) begin
                        if (substep_q == SUB_LAST) begin
                            if (NO_PAIRS) begin
                                state_q  <= ST_COMMIT;
                                commit_q <= 1'b1;
                            end else begin
                                state_q      <= ST_PAIRS;
                                pair_valid_q <= 1'b1;
                                pair_i_q     <= '0;
                                pair_j_q     <= IDX_W'(1);
                                pair_last_q  <= ONE_PAIR;
                            end
                        end else begin
                            substep_q     <= substep_q + SUB_W'(1);
                            state_q       <= ST_INTEG;
                            integ_start_q <= 1'b1;
                        end
                    end
                end
                ST_PAIRS: begin
                    if (pair_ready_i) begin
                        if (pair_last_q) begin
                            state_q      <= ST_COMMIT;
                            commit_q     <= 1'b1;
                            pair_valid_q <= 1'b0;
                            pair_last_q  <= 1'b0;
                            pair_i_q     <= '0;
                            pair_j_q     <= IDX_W'(1);
                        end else begin
                            pair_i_q    <= pair_i_d;
                            pair_j_q    <= pair_j_d;
                            pair_last_q <= pair_last_d;
                        end
                    end
                end
                ST_COMMIT: begin
                    frame_count_q <= frame_count_q + 16'd1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign integ_start_o = integ_start_q;
    assign pair_valid_o  = pair_valid_q;
    assign pair_i_o      = pair_i_q;
    assign pair_j_o      = pair_j_q;
    assign pair_last_o   = pair_last_q;
    assign commit_o      = commit_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign overrun_o     = overrun_q;
    assign frame_count_o = frame_count_q;
    assign state_dbg_o   = state_q;

endmodule
